ifu_prefetch: RTL and testbench

Parametrised instruction fetch unit that issues pipelined AXI-lite read requests ahead of decode and buffers returned instructions in a prefetch FIFO. It sits between the instruction memory read channel and the IDU.
It handles redirects from EX (jump or interrupt) by flushing buffered instructions and discarding in-flight responses. It supports up to MAX_OUTSTANDING requests in flight and selects a 32-bit instruction from a DATA_W-wide beat.

---
 rtl/ifu_prefetch_if.sv | 21 ++
 rtl/ifu_prefetch.sv | 157 +++++++++++++++
 tb/tb_ifu_prefetch.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_prefetch_if.sv
// AXI-lite read channel between the fetch unit (master) and instruction memory (slave).
// RRESP is present only when IFU_RRESP_CHECK_EN is defined.
interface ifu_prefetch_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic              ARVALID;
    logic [ADDR_W-1:0] ARADDR;
    logic              ARREADY;
    logic              RVALID;
    logic [DATA_W-1:0] RDATA;
    logic              RREADY;
`ifdef IFU_RRESP_CHECK_EN
    logic [1:0]        RRESP;
    modport master (output ARVALID, ARADDR, RREADY, input ARREADY, RVALID, RDATA, RRESP);
    modport slave  (input ARVALID, ARADDR, RREADY, output ARREADY, RVALID, RDATA, RRESP);
`else
    modport master (output ARVALID, ARADDR, RREADY, input ARREADY, RVALID, RDATA);
    modport slave  (input ARVALID, ARADDR, RREADY, output ARREADY, RVALID, RDATA);
`endif
endinterface

// File: rtl/ifu_prefetch.sv
// Instruction prefetcher: pipelined AR issue, in-order pc tracking, FWFT instruction FIFO.
// Define IFU_RRESP_CHECK_EN to add RRESP fault tagging and stop-on-fault issue gating.
module ifu_prefetch #(
    parameter int              ADDR_W          = 32,
    parameter int              XLEN            = 64,
    parameter int              DATA_W          = 64,
    parameter int              FIFO_DEPTH      = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_intr,
    input  logic [XLEN-1:0] intr_pc,
    input  logic            is_jump,
    input  logic [XLEN-1:0] jump_pc,
    ifu_prefetch_if.master  mem,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            ifu_valid,
    input  logic            idu_ready
`ifdef IFU_RRESP_CHECK_EN
    ,
    output logic            inst_fault_o
`endif
);
    localparam int CW  = $clog2(MAX_OUTSTANDING + 2);
    localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
`ifdef IFU_RRESP_CHECK_EN
        logic            fault;
`endif
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    logic [XLEN-1:0] fetch_pc, ar_pc, base_pc, target, r_pc;
    logic            ar_valid, redirect, hold, issue, credit_ok, halt_n;
    logic            ar_fire, r_fire, keep, pop, empty;
    logic [CW-1:0]   outstanding, outst_n, drop_cnt, drop_n;
    logic [XLEN-1:0] pcq [MAX_OUTSTANDING];
    logic [PW-1:0]   pcq_wr, pcq_rd;
    entry_t          fifo [FIFO_DEPTH];
    entry_t          head, new_entry;
    logic [FAW-1:0]  f_wr, f_rd;
    logic [FCW-1:0]  f_cnt, f_cnt_n;
    logic [31:0]     r_inst;

    function automatic logic [PW-1:0] pq_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign redirect = is_intr | is_jump;
    assign target   = is_intr ? intr_pc : jump_pc;
    assign base_pc  = redirect ? target : fetch_pc;

    assign mem.ARVALID = ar_valid;
    assign mem.ARADDR  = ar_pc[ADDR_W-1:0];
    assign mem.RREADY  = 1'b1;

    assign ar_fire = ar_valid & mem.ARREADY;
    assign hold    = ar_valid & ~mem.ARREADY;
    assign r_fire  = mem.RVALID & (outstanding != '0);
    assign keep    = r_fire & (drop_cnt == '0);
    assign r_pc    = pcq[pcq_rd];

    generate
        if (DATA_W == 64) begin : g_sel64
            assign r_inst = r_pc[2] ? mem.RDATA[63:32] : mem.RDATA[31:0];
        end else begin : g_sel32
            assign r_inst = mem.RDATA[31:0];
        end
    endgenerate

    assign outst_n = outstanding + CW'(ar_fire) - CW'(r_fire);

    // A redirect retires everything in flight, including an AR that is stuck
    // on the bus and will only be counted as outstanding once it is accepted.
    always_comb begin
        drop_n = drop_cnt;
        if (redirect)
            drop_n = outst_n + CW'(hold);
        else if (r_fire && drop_cnt != '0)
            drop_n = drop_cnt - CW'(1);
    end

    assign pop     = ifu_valid & idu_ready;
    assign f_cnt_n = redirect ? '0 : f_cnt + FCW'(keep) - FCW'(pop);

`ifdef IFU_RRESP_CHECK_EN
    logic stop, r_fault;
    assign r_fault = (mem.RRESP != 2'b00);
    assign halt_n  = redirect ? 1'b0 : (stop | (keep & r_fault));
    always_ff @(posedge clk) begin
        if (rst) stop <= 1'b0;
        else     stop <= halt_n;
    end
    assign new_entry = '{fault: r_fault, pc: r_pc, inst: r_inst};
`else
    assign halt_n    = 1'b0;
    assign new_entry = '{pc: r_pc, inst: r_inst};
`endif

    // Issue is decided on next-cycle counts so every kept response owns a FIFO slot.
    assign credit_ok = (outst_n < CW'(MAX_OUTSTANDING)) &&
                       ((int'(outst_n) - int'(drop_n) + int'(f_cnt_n)) < FIFO_DEPTH) &&
                       !halt_n;
    assign issue = !hold && credit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            ar_pc       <= '0;
            ar_valid    <= 1'b0;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            f_wr        <= '0;
            f_rd        <= '0;
            f_cnt       <= '0;
        end else begin
            fetch_pc    <= issue ? base_pc + XLEN'(4) : base_pc;
            ar_valid    <= hold | issue;
            if (issue) ar_pc <= base_pc;
            outstanding <= outst_n;
            drop_cnt    <= drop_n;
            if (ar_fire) pcq_wr <= pq_inc(pcq_wr);
            if (r_fire)  pcq_rd <= pq_inc(pcq_rd);
            f_cnt <= f_cnt_n;
            if (redirect) begin
                f_wr <= '0;
                f_rd <= '0;
            end else begin
                if (keep) f_wr <= f_wr + FAW'(1);
                if (pop)  f_rd <= f_rd + FAW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (ar_fire)            pcq[pcq_wr] <= ar_pc;
        if (keep && !redirect)  fifo[f_wr]  <= new_entry;
    end

    assign head      = fifo[f_rd];
    assign empty     = (f_cnt == '0);
    assign ifu_valid = !empty && !redirect;
    assign inst_o    = empty ? '0 : head.inst;
    assign pc_o      = empty ? '0 : head.pc;
`ifdef IFU_RRESP_CHECK_EN
    assign inst_fault_o = !empty && head.fault;
`endif
endmodule

// File: tb/tb_ifu_prefetch.sv
// Randomized bench for ifu_prefetch against a transaction-level queue model.
module tb_ifu_prefetch;
    localparam int          ADDR_W     = 32;
    localparam int          XLEN       = 64;
    localparam int          DATA_W     = 64;
    localparam int          FIFO_DEPTH = 4;
    localparam int          MAX_OUT    = 2;
    localparam logic [63:0] RESET_PC   = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, is_intr, is_jump, idu_ready, ifu_valid;
    logic [63:0] intr_pc, jump_pc, pc_o;
    logic [31:0] inst_o;
`ifdef IFU_RRESP_CHECK_EN
    logic        inst_fault_o;
`endif

    ifu_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ifu_prefetch #(
        .ADDR_W(ADDR_W), .XLEN(XLEN), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
        .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .rst(rst), .is_intr(is_intr), .intr_pc(intr_pc),
        .is_jump(is_jump), .jump_pc(jump_pc), .mem(bus),
        .inst_o(inst_o), .pc_o(pc_o), .ifu_valid(ifu_valid), .idu_ready(idu_ready)
`ifdef IFU_RRESP_CHECK_EN
        , .inst_fault_o(inst_fault_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] pc; logic stale; } req_t;
    typedef struct { logic [63:0] pc; logic [31:0] inst; logic fault; } ent_t;

    req_t        inflight[$];
    ent_t        mfifo[$];
    logic [63:0] ar_exp, stale_pc;
    logic        stale_pend, prev_stall, stop_q;
    logic [31:0] prev_addr;
    int          checks = 0, errors = 0, pops = 0, fault_pct = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [63:0] a);
        logic [31:0] w;
        w = a[31:0] & ~32'h3;
        return (w * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [63:0] beat_at(input logic [63:0] a);
        logic [63:0] b;
        b = a & ~64'h7;
        return {word_at(b + 64'd4), word_at(b)};
    endfunction

    function automatic logic [63:0] rand_target();
        logic [15:0] o;
        o = 16'($urandom) & 16'hfffc;
        if ($urandom_range(9) == 0) return 64'hFFFF_FFFF_FFFF_FFF0 + 64'(o[3:0]);
        return {32'h0, 16'h8000, o};
    endfunction

    task automatic model_reset();
        inflight.delete();
        mfifo.delete();
        ar_exp     = RESET_PC;
        stale_pend = 1'b0;
        prev_stall = 1'b0;
        stop_q     = 1'b0;
        prev_addr  = '0;
    endtask

    // redir: 0 none, 1 jump, 2 intr, 3 both, 4 random (5%) with random targets
    task automatic drive(input int ar_pct, input int r_pct, input int idu_pct, input int redir);
        int r;
        r = redir;
        bus.ARREADY = ($urandom_range(99) < ar_pct);
        if (inflight.size() != 0 && $urandom_range(99) < r_pct) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = beat_at(inflight[0].pc);
`ifdef IFU_RRESP_CHECK_EN
            bus.RRESP  = ($urandom_range(99) < fault_pct) ? 2'd2 : 2'd0;
`endif
        end else begin
            bus.RVALID = 1'b0;
            bus.RDATA  = {$urandom, $urandom};
`ifdef IFU_RRESP_CHECK_EN
            bus.RRESP  = 2'd0;
`endif
        end
        idu_ready = ($urandom_range(99) < idu_pct);
        if (redir == 4) begin
            r = ($urandom_range(99) < 5) ? int'($urandom_range(3, 1)) : 0;
            intr_pc = rand_target();
            jump_pc = rand_target();
        end
        is_jump = (r == 1 || r == 3);
        is_intr = (r == 2 || r == 3);
    endtask

    task automatic eval_cycle();
        logic        redir, do_pop, fault;
        logic [63:0] tgt;
        req_t        q;
        ent_t        e;
        redir = is_intr | is_jump;
        tgt   = is_intr ? intr_pc : jump_pc;

        chk("ifu_valid", ifu_valid, 64'((mfifo.size() != 0) && !redir));
        if (mfifo.size() != 0) begin
            chk("pc_o", pc_o, mfifo[0].pc);
            chk("inst_o", inst_o, mfifo[0].inst);
        end else begin
            chk("pc_o_empty", pc_o, 64'd0);
            chk("inst_o_empty", inst_o, 64'd0);
        end
`ifdef IFU_RRESP_CHECK_EN
        chk("inst_fault_o", inst_fault_o, (mfifo.size() != 0) ? 64'(mfifo[0].fault) : 64'd0);
`endif
        if (prev_stall) begin
            chk("ar_hold_valid", bus.ARVALID, 64'd1);
            chk("ar_hold_addr", bus.ARADDR, prev_addr);
        end
        if (stop_q && !prev_stall) chk("ar_after_fault", bus.ARVALID, 64'd0);

        if (bus.ARVALID && bus.ARREADY) begin
            if (stale_pend) begin
                q.pc = stale_pc; q.stale = 1'b1; stale_pend = 1'b0;
            end else begin
                q.pc = ar_exp; q.stale = 1'b0; ar_exp = ar_exp + 64'd4;
            end
            chk("araddr", bus.ARADDR, 64'(q.pc[31:0]));
            inflight.push_back(q);
            chk("outstanding_le_max", 64'(inflight.size() <= MAX_OUT), 64'd1);
        end

        do_pop = (mfifo.size() != 0) && !redir && idu_ready;
        if (do_pop) begin
            void'(mfifo.pop_front());
            pops++;
        end
        if (bus.RVALID) begin
            q = inflight.pop_front();
            if (!q.stale) begin
                fault = 1'b0;
`ifdef IFU_RRESP_CHECK_EN
                fault = (bus.RRESP != 2'd0);
`endif
                e.pc = q.pc; e.inst = word_at(q.pc); e.fault = fault;
                mfifo.push_back(e);
                if (fault && !redir) stop_q = 1'b1;
                chk("fifo_le_depth", 64'(mfifo.size() <= FIFO_DEPTH), 64'd1);
            end
        end
        if (redir) begin
            mfifo.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            if (bus.ARVALID && !bus.ARREADY && !stale_pend) begin
                stale_pend = 1'b1;
                stale_pc   = ar_exp;
            end
            ar_exp = tgt;
            stop_q = 1'b0;
        end
        prev_stall = bus.ARVALID && !bus.ARREADY;
        prev_addr  = bus.ARADDR;
    endtask

    task automatic cyc(input int ar_pct, input int r_pct, input int idu_pct, input int redir);
        @(posedge clk);
        #1;
        drive(ar_pct, r_pct, idu_pct, redir);
        @(negedge clk);
        eval_cycle();
    endtask

    task automatic idle_inputs();
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0; bus.RDATA = '0;
`ifdef IFU_RRESP_CHECK_EN
        bus.RRESP = 2'd0;
`endif
        idu_ready = 1'b0; is_intr = 1'b0; is_jump = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_arvalid"}, bus.ARVALID, 64'd0);
        chk({tag, "_ifu_valid"}, ifu_valid, 64'd0);
        chk({tag, "_inst_o"}, inst_o, 64'd0);
        chk({tag, "_pc_o"}, pc_o, 64'd0);
        chk({tag, "_rready"}, bus.RREADY, 64'd1);
`ifdef IFU_RRESP_CHECK_EN
        chk({tag, "_fault"}, inst_fault_o, 64'd0);
`endif
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        check_reset_state(tag);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; intr_pc = '0; jump_pc = '0;
        idle_inputs();
        model_reset();
        do_reset("reset");

        // streaming from RESET_PC
        repeat (12) cyc(100, 100, 100, 0);

        // IDU stalled: buffer fills exactly, issue stops
        repeat (25) cyc(100, 100, 0, 0);
        chk("full_entries", 64'(mfifo.size()), 64'(FIFO_DEPTH));
        chk("full_inflight", 64'(inflight.size()), 64'd0);
        chk("full_arvalid", bus.ARVALID, 64'd0);
        repeat (10) cyc(100, 100, 100, 0);

        // interrupt while an AR is stalled
        repeat (3) cyc(100, 100, 100, 0);
        repeat (2) cyc(0, 100, 100, 0);
        intr_pc = 64'h8000_0100;
        cyc(0, 100, 100, 2);
        repeat (2) cyc(0, 100, 100, 0);
        repeat (10) cyc(100, 100, 100, 0);

        // jump with responses in flight and a partly full buffer
        repeat (4) cyc(100, 40, 0, 0);
        jump_pc = 64'h8000_1000;
        cyc(100, 100, 100, 1);
        repeat (10) cyc(100, 100, 100, 0);

        // intr and jump together
        intr_pc = 64'h100; jump_pc = 64'h200;
        cyc(100, 100, 100, 3);
        repeat (8) cyc(100, 100, 100, 0);

        // wrap at the top of the PC range
        jump_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        cyc(100, 100, 100, 1);
        repeat (10) cyc(100, 100, 100, 0);

        // random traffic, then reset mid-burst and continue
        fault_pct = 4;
        repeat (3000) cyc($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(100, 0), 4);
        do_reset("midreset");
        fault_pct = 0;
        repeat (6) cyc(100, 100, 100, 0);
        fault_pct = 4;
        repeat (1000) cyc($urandom_range(100, 20), $urandom_range(100, 10), $urandom_range(100, 0), 4);
        fault_pct = 0;
        repeat (30) cyc(100, 100, 100, 0);

        chk("progress", 64'(pops > 200), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
